// File: rtl/riscv_boot_loader_pkg.sv
// Shared types and defaults for the byte-stream boot loader feeding riscv_mcu.
// Frame layout: MAGIC, LEN_LO, LEN_HI, 4*N little-endian data bytes, CSUM.
package riscv_boot_loader_pkg;

    localparam int          ADDR_W_DEF     = 10;
    localparam int          IMEM_WORDS_DEF = 1024;
    localparam logic [7:0]  MAGIC_DEF      = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_RUN    = 3'd5
    } state_t;

    // Byte 3 arrives last; the three earlier bytes sit in the shift register as {b2,b1,b0}.
    function automatic logic [31:0] pack_word(input logic [23:0] low, input logic [7:0] b3);
        return {b3, low};
    endfunction

endpackage

// File: rtl/riscv_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// Modport master is the loader side; slave is the source/memory side.
interface riscv_boot_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/riscv_boot_loader.sv
// Receives a framed program image, packs bytes into LE words, writes them to imem and
// releases the CPU reset only after the checksum over the data bytes matches.
module riscv_boot_loader
    import riscv_boot_loader_pkg::*;
#(
    parameter int         ADDR_W     = ADDR_W_DEF,
    parameter int         IMEM_WORDS = IMEM_WORDS_DEF,
    parameter logic [7:0] MAGIC      = MAGIC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    riscv_boot_loader_if.master     bus,
    output logic                    cpu_rst_n_o,
    output logic                    load_done_o,
    output logic                    load_err_o,
    output logic [ADDR_W:0]         words_loaded_o,
    output state_t                  state_o
);

    localparam logic [15:0] MAX_WORDS = 16'(IMEM_WORDS);

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          sum_q, sum_d;
    logic [1:0]          lane_q, lane_d;
    logic [ADDR_W:0]     word_q, word_d;
    logic [23:0]         shift_q, shift_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                accept;
    logic [15:0]         len_rx;

    assign accept = bus.in_valid && in_ready_q;
    assign len_rx = {bus.in_data, len_lo_q};

    always_comb begin
        state_d     = state_q;
        in_ready_d  = 1'b1;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        sum_d       = sum_q;
        lane_d      = lane_q;
        word_d      = word_q;
        shift_d     = shift_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rst_n_d = cpu_rst_n_q;
        done_d      = done_q;
        err_d       = err_q;
        words_d     = words_q;

        unique case (state_q)
            S_IDLE, S_RUN: begin
                // MAGIC in RUN is a live reload: CPU goes back into reset first.
                if (accept && bus.in_data == MAGIC) begin
                    state_d     = S_LEN_LO;
                    err_d       = 1'b0;
                    words_d     = '0;
                    lane_d      = '0;
                    word_d      = '0;
                    sum_d       = '0;
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_lo_d = bus.in_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = len_rx;
                    if (len_rx > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (len_rx == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    sum_d  = sum_q + bus.in_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = word_q[ADDR_W-1:0];
                        wdata_d = pack_word(shift_q, bus.in_data);
                        words_d = words_q + (ADDR_W+1)'(1);
                        word_d  = word_q + (ADDR_W+1)'(1);
                        if (16'(word_q) + 16'd1 == len_q) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        shift_d = {bus.in_data, shift_q[23:8]};
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (bus.in_data == sum_q) begin
                        state_d     = S_RUN;
                        done_d      = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            len_lo_q    <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            lane_q      <= '0;
            word_q      <= '0;
            shift_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            shift_q     <= shift_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
            words_q     <= words_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_rst_n_o    = cpu_rst_n_q;
    assign load_done_o    = done_q;
    assign load_err_o     = err_q;
    assign words_loaded_o = words_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Bench for riscv_boot_loader: frame-level reference model, write scoreboard,
// a vector table, directed corner sequences and randomized frames.
module tb_riscv_boot_loader;
    import riscv_boot_loader_pkg::*;

    localparam int AW   = 10;
    localparam int MAXW = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_boot_loader_if #(.ADDR_W(AW)) bus ();

    logic          cpu_rst_n;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;
    state_t        state;

    riscv_boot_loader #(.ADDR_W(AW), .IMEM_WORDS(MAXW), .MAGIC(8'hA5)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.master),
        .cpu_rst_n_o    (cpu_rst_n),
        .load_done_o    (load_done),
        .load_err_o     (load_err),
        .words_loaded_o (words_loaded),
        .state_o        (state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW+31:0] exp_q[$];
    logic [7:0]     frame_q[$];

    typedef struct {
        int n;
        bit good;
        int junk;
        int gap;
        bit exp_done;
        bit exp_err;
        int exp_words;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every imem write must match the oldest expected {addr, data}.
    always @(negedge clk) begin : write_mon
        logic [AW+31:0] e;
        if (!rst && bus.imem_we === 1'b1) begin
            check("write_pending", 32'(exp_q.size() > 0), 32'd1);
            check("we_with_cpu_running", 32'(cpu_rst_n), 32'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("imem_addr", 32'(bus.imem_addr), 32'(e[AW+31:32]));
                check("imem_wdata", bus.imem_wdata, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int w;
        gap = $urandom_range(max_gap, 0);
        w = 0;
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_queue(input int max_gap);
        while (frame_q.size() > 0) send_byte(frame_q.pop_front(), max_gap);
    endtask

    task automatic push_junk(input int k);
        logic [7:0] j;
        for (int i = 0; i < k; i++) begin
            j = 8'($urandom_range(255, 0));
            if (j == 8'hA5) j = 8'h00;
            frame_q.push_back(j);
        end
    endtask

    // Builds a frame of random words; oversize frames carry only the header.
    task automatic build_frame(input int n, input bit good);
        logic [15:0] nn;
        logic [7:0]  sum;
        logic [31:0] w;
        nn  = 16'(n);
        sum = 8'd0;
        frame_q.push_back(8'hA5);
        frame_q.push_back(nn[7:0]);
        frame_q.push_back(nn[15:8]);
        if (n <= MAXW) begin
            for (int i = 0; i < n; i++) begin
                w = $urandom();
                for (int k = 0; k < 4; k++) begin
                    frame_q.push_back(w[8*k +: 8]);
                    sum = sum + w[8*k +: 8];
                end
                exp_q.push_back({AW'(i), w});
            end
            frame_q.push_back(good ? sum : (sum ^ 8'h5A));
        end
    endtask

    // Outcome of a whole frame derived from the frame rules alone.
    task automatic model_frame(input int n, input bit good, output bit done, output bit err, output int words);
        bit fits;
        fits  = (n <= MAXW);
        done  = fits && good;
        err   = !done;
        words = fits ? n : 0;
    endtask

    task automatic check_outcome(input string tag, input bit done, input bit err, input int words);
        check({tag, "_load_done"}, 32'(load_done), 32'(done));
        check({tag, "_load_err"}, 32'(load_err), 32'(err));
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(done));
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'(words));
        check({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        check({tag, "_load_done"}, 32'(load_done), 32'd0);
        check({tag, "_load_err"}, 32'(load_err), 32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
        check({tag, "_state"}, 32'(state), 32'(S_IDLE));
    endtask

    task automatic push_t1_frame(input logic [7:0] csum);
        logic [7:0] t1[11];
        t1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00, 8'h6f, 8'h00, 8'h00, 8'h00};
        foreach (t1[i]) frame_q.push_back(t1[i]);
        frame_q.push_back(csum);
        exp_q.push_back({AW'(0), 32'h00a00513});
        exp_q.push_back({AW'(1), 32'h0000006f});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        bit   m_done, m_err;
        int   m_words;
        logic [7:0] b;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        vecs[0] = '{n: 1,    good: 1, junk: 3, gap: 0, exp_done: 1, exp_err: 0, exp_words: 1};
        vecs[1] = '{n: 2,    good: 0, junk: 0, gap: 1, exp_done: 0, exp_err: 1, exp_words: 2};
        vecs[2] = '{n: 3,    good: 1, junk: 2, gap: 3, exp_done: 1, exp_err: 0, exp_words: 3};
        vecs[3] = '{n: 0,    good: 1, junk: 0, gap: 0, exp_done: 1, exp_err: 0, exp_words: 0};
        vecs[4] = '{n: 1025, good: 1, junk: 1, gap: 1, exp_done: 0, exp_err: 1, exp_words: 0};
        vecs[5] = '{n: 1024, good: 1, junk: 0, gap: 0, exp_done: 1, exp_err: 0, exp_words: 1024};
        vecs[6] = '{n: 4,    good: 0, junk: 0, gap: 2, exp_done: 0, exp_err: 1, exp_words: 4};
        vecs[7] = '{n: 2,    good: 1, junk: 1, gap: 2, exp_done: 1, exp_err: 0, exp_words: 2};

        // Reset state and the one-cycle in_ready hold-off.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values("por");
        @(posedge clk); #1;
        check("por_in_ready_after", 32'(bus.in_ready), 32'd1);

        // Known program: checksum over data bytes only is 0x27.
        push_t1_frame(8'h27);
        b = frame_q.pop_back();
        send_queue(0);
        check("t1_cpu_held_before_csum", 32'(cpu_rst_n), 32'd0);
        check("t1_done_before_csum", 32'(load_done), 32'd0);
        send_byte(b, 0);
        check_outcome("t1", 1'b1, 1'b0, 2);

        // Bad checksum, then the good frame again clears the error.
        push_t1_frame(8'h00);
        send_queue(0);
        check_outcome("t2_bad", 1'b0, 1'b1, 2);
        push_t1_frame(8'h27);
        send_queue(1);
        check_outcome("t2_good", 1'b1, 1'b0, 2);

        // Live reload from RUN: MAGIC alone drops CPU reset and done next cycle.
        build_frame(2, 1'b1);
        send_byte(frame_q.pop_front(), 0);
        check("t5_cpu_rst_n_after_magic", 32'(cpu_rst_n), 32'd0);
        check("t5_done_after_magic", 32'(load_done), 32'd0);
        send_queue(0);
        check_outcome("t5", 1'b1, 1'b0, 2);

        // Vector table: junk prefix, gaps, empty, oversize and full-size images.
        for (int i = 0; i < 8; i++) begin
            push_junk(vecs[i].junk);
            build_frame(vecs[i].n, vecs[i].good);
            send_queue(vecs[i].gap);
            check_outcome($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_words);
        end

        // Reset in the middle of DATA after one word has been written.
        build_frame(3, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(frame_q.pop_front(), 2);
        @(posedge clk); #1;
        check("t6_pending_writes", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        frame_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("t6");
        build_frame(3, 1'b1);
        send_queue(2);
        check_outcome("t6_reload", 1'b1, 1'b0, 3);

        // Randomized frames against the frame-level model.
        for (int i = 0; i < 20; i++) begin
            int  n;
            bit  g;
            n = $urandom_range(6, 0);
            g = 1'($urandom_range(1, 0));
            push_junk($urandom_range(2, 0));
            build_frame(n, g);
            send_queue($urandom_range(2, 0));
            model_frame(n, g, m_done, m_err, m_words);
            check_outcome($sformatf("rnd%0d", i), m_done, m_err, m_words);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
